// File: rtl/mtm_alu_serial_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mtm_alu_serial_tx : serialises one ALU result packet (C + CTL) onto sout  |
// | as 11-bit frames. Optional MTM_ALU_TX_SKID_EN adds a 1-entry hold buffer. |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module mtm_alu_serial_tx #(
   parameter int DATA_BYTES = 4,   // 1..4
   parameter int IDLE_GAP   = 1    // 0..15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_c,
   input  logic [7:0]  in_ctl,
   output logic        sout,
   output logic        busy
);

   localparam int         SW          = 8*DATA_BYTES + 8;
   localparam logic [2:0] c_FRAMES_M1 = 3'(DATA_BYTES);
   localparam logic [3:0] c_GAP_M1    = 4'(IDLE_GAP - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_TYPE  = 3'd2,
      S_DATA  = 3'd3,
      S_STOP  = 3'd4,
      S_GAP   = 3'd5
   } state_t;

   state_t          r_state;
   logic [SW-1:0]   r_sh;
   logic [2:0]      r_bit_cnt;
   logic [2:0]      r_frame_cnt;
   logic [3:0]      r_gap_cnt;
   logic            r_sout;
   logic            r_busy;

   logic            w_launch;
   logic [31:0]     w_c;
   logic [7:0]      w_ctl;
   logic [SW-1:0]   w_load_sh;
   logic [2:0]      w_load_frames;

`ifdef MTM_ALU_TX_SKID_EN
   logic            r_hold_full;
   logic [31:0]     r_hold_c;
   logic [7:0]      r_hold_ctl;

   // A packet offered while busy parks here and launches from the next IDLE cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold_full <= 1'b0;
         r_hold_c    <= '0;
         r_hold_ctl  <= '0;
      end else if (w_launch && r_hold_full) begin
         r_hold_full <= 1'b0;
      end else if (in_valid && !r_hold_full && (r_state != S_IDLE)) begin
         r_hold_full <= 1'b1;
         r_hold_c    <= in_c;
         r_hold_ctl  <= in_ctl;
      end
   end

   assign w_launch = (r_state == S_IDLE) && (r_hold_full || in_valid);
   assign w_c      = r_hold_full ? r_hold_c   : in_c;
   assign w_ctl    = r_hold_full ? r_hold_ctl : in_ctl;
   assign in_ready = !r_hold_full;
`else
   assign w_launch = (r_state == S_IDLE) && in_valid;
   assign w_c      = in_c;
   assign w_ctl    = in_ctl;
   assign in_ready = !r_busy;
`endif

   // Error packets carry only the CTL byte, so it is placed at the shift-out end.
   assign w_load_sh     = w_ctl[7] ? {w_ctl, {(SW-8){1'b0}}}
                                   : {w_c[8*DATA_BYTES-1:0], w_ctl};
   assign w_load_frames = w_ctl[7] ? 3'd0 : c_FRAMES_M1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_sh        <= '0;
         r_bit_cnt   <= '0;
         r_frame_cnt <= '0;
         r_gap_cnt   <= '0;
         r_sout      <= 1'b1;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_sout <= 1'b1;
               if (w_launch) begin
                  r_state     <= S_START;
                  r_sh        <= w_load_sh;
                  r_frame_cnt <= w_load_frames;
                  r_busy      <= 1'b1;
               end
            end
            S_START: begin
               r_sout  <= 1'b0;
               r_state <= S_TYPE;
            end
            S_TYPE: begin
               r_sout    <= (r_frame_cnt == 3'd0);
               r_bit_cnt <= 3'd7;
               r_state   <= S_DATA;
            end
            S_DATA: begin
               r_sout    <= r_sh[SW-1];
               r_sh      <= {r_sh[SW-2:0], 1'b0};
               r_bit_cnt <= r_bit_cnt - 3'd1;
               if (r_bit_cnt == 3'd0) r_state <= S_STOP;
            end
            S_STOP: begin
               r_sout <= 1'b1;
               if (r_frame_cnt != 3'd0) begin
                  r_frame_cnt <= r_frame_cnt - 3'd1;
                  r_state     <= S_START;
               end else if (IDLE_GAP != 0) begin
                  r_gap_cnt <= c_GAP_M1;
                  r_state   <= S_GAP;
               end else begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            S_GAP: begin
               r_sout <= 1'b1;
               if (r_gap_cnt == 4'd0) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_gap_cnt <= r_gap_cnt - 4'd1;
               end
            end
            default: begin
               r_sout  <= 1'b1;
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign sout = r_sout;
   assign busy = r_busy;

endmodule
`default_nettype wire
